// File: rtl/conv_mac_engine_if.sv
// conv_mac_engine_if
//   Bundles the control handshake and the three RAM ports of the
//   convolution engine.
//   master : engine side (drives addresses, write port, busy/done)
//   slave  : environment side (drives start, w_base and RAM read data)
//   Signals:
//     start    - 1-cycle pulse requesting a layer pass
//     w_base   - weight RAM base address, latched on accepted start
//     busy     - pass in progress
//     done     - 1-cycle pulse after the final output write
//     in_addr  - input RAM address,  in_data  - signed input pixel
//     w_addr   - weight RAM address, w_data   - signed weight
//     out_addr - output RAM address, out_data - signed result, out_ld - write enable
interface conv_mac_engine_if;
  logic        start;
  logic [9:0]  w_base;
  logic        busy;
  logic        done;
  logic [9:0]  in_addr;
  logic [7:0]  in_data;
  logic [9:0]  w_addr;
  logic [7:0]  w_data;
  logic [11:0] out_addr;
  logic [7:0]  out_data;
  logic        out_ld;

  modport master (
    input  start, w_base, in_data, w_data,
    output busy, done, in_addr, w_addr, out_addr, out_data, out_ld
  );

  modport slave (
    output start, w_base, in_data, w_data,
    input  busy, done, in_addr, w_addr, out_addr, out_data, out_ld
  );
endinterface

// File: rtl/conv_mac_engine.sv
// conv_mac_engine
//   Single-channel KSxKS convolution sequencer (stride 1, no padding).
//   Walks every valid output pixel in raster order, spends one cycle per
//   kernel tap accumulating signed 8x8 products, then one cycle writing
//   the requantized (arithmetic shift) and 8-bit clamped result.
//   Ports:
//     Clk   - clock, all state on posedge
//     reset - asynchronous, active-high
//     bus   - conv_mac_engine_if.master (start/w_base/busy/done and the
//             input, weight and output RAM ports)
//   Configuration:
//     CONV_RELU_EN defined   -> results clamp to [0,127] (fused ReLU)
//     CONV_RELU_EN undefined -> signed saturation to [-128,127]
module conv_mac_engine #(
  parameter int IMG_W = 32,
  parameter int KS    = 3,
  parameter int ACC_W = 20,
  parameter int SHIFT = 7
) (
  input  logic              Clk,
  input  logic              reset,
  conv_mac_engine_if.master bus
);

  localparam int OUT_W = IMG_W - KS + 1;

  localparam logic [9:0]  IMG_W_A  = 10'(IMG_W);
  localparam logic [9:0]  KS_LAST  = 10'(KS - 1);
  localparam logic [9:0]  OUT_LAST = 10'(OUT_W - 1);
  localparam logic [11:0] OUT_W_A  = 12'(OUT_W);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
`ifdef CONV_RELU_EN
  localparam logic signed [ACC_W-1:0] SAT_LO = '0;
`else
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);
`endif

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [9:0]              w_base_q, w_base_d;
  logic [9:0]              row_q, row_d;
  logic [9:0]              col_q, col_d;
  logic [9:0]              kr_q, kr_d;
  logic [9:0]              kc_q, kc_d;
  logic [9:0]              tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [11:0]             out_addr_q, out_addr_d;
  logic [7:0]              out_data_q, out_data_d;

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              clamped;
  logic [11:0]             pix_addr;

  // Datapath: signed product of the current tap, requantized/clamped
  // result of the finished accumulation, and the raster output address.
  always_comb begin
    prod     = 16'($signed(bus.in_data)) * 16'($signed(bus.w_data));
    shifted  = acc_q >>> SHIFT;
    pix_addr = 12'(row_q) * OUT_W_A + 12'(col_q);
    if (shifted > SAT_HI) begin
      clamped = SAT_HI[7:0];
    end else if (shifted < SAT_LO) begin
      clamped = SAT_LO[7:0];
    end else begin
      clamped = shifted[7:0];
    end
  end

  // Output decode. RAM addresses are only meaningful in MAC and are held
  // at zero elsewhere; the write port shows the live result during WRITE
  // and the last written value at all other times.
  always_comb begin
    bus.busy     = (state_q == MAC) || (state_q == WRITE);
    bus.done     = (state_q == DONE);
    bus.out_ld   = (state_q == WRITE);
    bus.in_addr  = '0;
    bus.w_addr   = '0;
    bus.out_addr = out_addr_q;
    bus.out_data = out_data_q;
    if (state_q == MAC) begin
      bus.in_addr = (row_q + kr_q) * IMG_W_A + col_q + kc_q;
      // 10-bit add so the weight address wraps modulo 1024.
      bus.w_addr  = w_base_q + tap_q;
    end
    if (state_q == WRITE) begin
      bus.out_addr = pix_addr;
      bus.out_data = clamped;
    end
  end

  // Next-state logic: kernel taps walk row-major inside a pixel, pixels
  // walk in raster order; a start outside IDLE is ignored.
  always_comb begin
    state_d    = state_q;
    w_base_d   = w_base_q;
    row_d      = row_q;
    col_d      = col_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = MAC;
          w_base_d = bus.w_base;
          row_d    = '0;
          col_d    = '0;
          kr_d     = '0;
          kc_d     = '0;
          tap_d    = '0;
          acc_d    = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        tap_d = tap_q + 10'd1;
        if (kc_q == KS_LAST) begin
          kc_d = '0;
          if (kr_q == KS_LAST) begin
            kr_d    = '0;
            tap_d   = '0;
            state_d = WRITE;
          end else begin
            kr_d = kr_q + 10'd1;
          end
        end else begin
          kc_d = kc_q + 10'd1;
        end
      end
      WRITE: begin
        out_addr_d = pix_addr;
        out_data_d = clamped;
        acc_d      = '0;
        state_d    = MAC;
        if (col_q == OUT_LAST) begin
          col_d = '0;
          if (row_q == OUT_LAST) begin
            row_d   = '0;
            state_d = DONE;
          end else begin
            row_d = row_q + 10'd1;
          end
        end else begin
          col_d = col_q + 10'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any pass in flight immediately.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      w_base_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      tap_q      <= '0;
      acc_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      w_base_q   <= w_base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      tap_q      <= tap_d;
      acc_q      <= acc_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine
//   Bench for conv_mac_engine. Two engines share the clock, reset and RAM
//   contents: one with SHIFT=0 and one with SHIFT=7. Expected results come
//   from a plain-arithmetic convolution model over the bench RAM arrays.
//   Honours CONV_RELU_EN the same way the design does.
module tb_conv_mac_engine;

  localparam int IMG_W    = 32;
  localparam int KS       = 3;
  localparam int OUT_W    = IMG_W - KS + 1;
  localparam int NPIX     = OUT_W * OUT_W;
  localparam int PASS_CYC = NPIX * (KS * KS + 1);

  logic Clk = 1'b0;
  logic reset;

  always #5 Clk = ~Clk;

  conv_mac_engine_if bus0();
  conv_mac_engine_if bus7();

  logic signed [7:0] in_mem [0:1023];
  logic signed [7:0] w_mem  [0:1023];

  logic       start_drv;
  logic [9:0] wbase_drv;
  int         sel;

  assign bus0.start   = start_drv && (sel == 0);
  assign bus7.start   = start_drv && (sel == 1);
  assign bus0.w_base  = wbase_drv;
  assign bus7.w_base  = wbase_drv;
  assign bus0.in_data = in_mem[bus0.in_addr];
  assign bus0.w_data  = w_mem[bus0.w_addr];
  assign bus7.in_data = in_mem[bus7.in_addr];
  assign bus7.w_data  = w_mem[bus7.w_addr];

  conv_mac_engine #(.IMG_W(IMG_W), .KS(KS), .ACC_W(20), .SHIFT(0)) u_dut0 (
    .Clk(Clk), .reset(reset), .bus(bus0.master)
  );

  conv_mac_engine #(.IMG_W(IMG_W), .KS(KS), .ACC_W(20), .SHIFT(7)) u_dut7 (
    .Clk(Clk), .reset(reset), .bus(bus7.master)
  );

  // Observation mux onto whichever engine the running test drives.
  logic        m_busy, m_done, m_ld;
  logic [11:0] m_addr;
  logic [7:0]  m_data;
  logic [9:0]  m_iaddr, m_waddr;

  always_comb begin
    if (sel == 0) begin
      m_busy = bus0.busy;  m_done = bus0.done;  m_ld = bus0.out_ld;
      m_addr = bus0.out_addr; m_data = bus0.out_data;
      m_iaddr = bus0.in_addr; m_waddr = bus0.w_addr;
    end else begin
      m_busy = bus7.busy;  m_done = bus7.done;  m_ld = bus7.out_ld;
      m_addr = bus7.out_addr; m_data = bus7.out_data;
      m_iaddr = bus7.in_addr; m_waddr = bus7.w_addr;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [11:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [9:0]  wa_q      [$];
  int          busy_rise, done_at, busy_cnt, done_cnt;
  bit          timed_out;

  // Reference convolution for one output pixel.
  function automatic int model_pixel(int r, int c, int base, int shift);
    int sum = 0;
    int v;
    for (int kr = 0; kr < KS; kr++) begin
      for (int kc = 0; kc < KS; kc++) begin
        sum += int'(in_mem[(r + kr) * IMG_W + c + kc]) *
               int'(w_mem[(base + kr * KS + kc) % 1024]);
      end
    end
    v = sum >>> shift;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
`else
    if (v < -128) v = -128;
`endif
    if (v > 127) v = 127;
    return v;
  endfunction

  // Pulses start on the selected engine and records everything it does
  // until one pass completes, a cycle budget runs out, or stop_at is hit.
  // Sample index 0 is the first falling edge after start was taken.
  task automatic applyStimulus(input int which, input logic [9:0] base,
                               input int extra_starts, input int stop_at);
    wr_addr_q.delete();
    wr_data_q.delete();
    wa_q.delete();
    busy_rise = -1; done_at = -1; busy_cnt = 0; done_cnt = 0; timed_out = 0;
    sel = which;
    wbase_drv = base;
    @(negedge Clk);
    start_drv = 1'b1;
    for (int n = 0; n < PASS_CYC + 200; n++) begin
      @(negedge Clk);
      start_drv = 1'b0;
      if (m_busy) begin
        busy_cnt++;
        if (busy_rise < 0) busy_rise = n;
        if (!m_ld) wa_q.push_back(m_waddr);
      end
      if (m_ld) begin
        wr_addr_q.push_back(m_addr);
        wr_data_q.push_back(m_data);
      end
      if (m_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (stop_at > 0 && n == stop_at) return;
      if (done_at >= 0 && n > done_at + 2) return;
      if (extra_starts > 0 && n >= 100 && n < 100 + extra_starts * 50 && (n % 50) == 0)
        start_drv = 1'b1;
    end
    start_drv = 1'b0;
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    logic [52:0] v0, v7;
    reset = 1'b1; start_drv = 1'b0; wbase_drv = '0; sel = 0;
    repeat (3) @(negedge Clk);
    v0 = {bus0.busy, bus0.done, bus0.out_ld, bus0.out_addr, bus0.out_data, bus0.in_addr, bus0.w_addr};
    v7 = {bus7.busy, bus7.done, bus7.out_ld, bus7.out_addr, bus7.out_data, bus7.in_addr, bus7.w_addr};
    total++;
    if (v0 !== '0) begin bad++; $display("[TB] FAIL reset_held_dut0: got %h expected 0", v0); end
    total++;
    if (v7 !== '0) begin bad++; $display("[TB] FAIL reset_held_dut7: got %h expected 0", v7); end
    reset = 1'b0;
    repeat (2) @(negedge Clk);
    v0 = {bus0.busy, bus0.done, bus0.out_ld, bus0.out_addr, bus0.out_data, bus0.in_addr, bus0.w_addr};
    v7 = {bus7.busy, bus7.done, bus7.out_ld, bus7.out_addr, bus7.out_data, bus7.in_addr, bus7.w_addr};
    total++;
    if (v0 !== '0) begin bad++; $display("[TB] FAIL reset_idle_dut0: got %h expected 0", v0); end
    total++;
    if (v7 !== '0) begin bad++; $display("[TB] FAIL reset_idle_dut7: got %h expected 0", v7); end
  endtask

  task automatic test_ones();
    for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'sd1; w_mem[i] = 8'sd1; end
    applyStimulus(0, 10'd0, 0, 0);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL ones_timeout: got %0d expected 0", timed_out); end
    total++;
    if (wr_addr_q.size() != NPIX) begin bad++; $display("[TB] FAIL ones_writes: got %0d expected %0d", wr_addr_q.size(), NPIX); end
    total++;
    if (busy_cnt != PASS_CYC) begin bad++; $display("[TB] FAIL ones_busy_cycles: got %0d expected %0d", busy_cnt, PASS_CYC); end
    total++;
    if (busy_rise != 0) begin bad++; $display("[TB] FAIL ones_busy_rise: got %0d expected 0", busy_rise); end
    total++;
    if (done_at - busy_rise != PASS_CYC) begin bad++; $display("[TB] FAIL ones_done_latency: got %0d expected %0d", done_at - busy_rise, PASS_CYC); end
    total++;
    if (done_cnt != 1) begin bad++; $display("[TB] FAIL ones_done_pulses: got %0d expected 1", done_cnt); end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== 12'(i)) begin bad++; $display("[TB] FAIL ones_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], i); end
      total++;
      if (wr_data_q[i] !== 8'd9) begin bad++; $display("[TB] FAIL ones_data[%0d]: got %0d expected 9", i, wr_data_q[i]); end
    end
    total++;
    if ({m_busy, m_done, m_ld, m_iaddr, m_waddr} !== '0) begin
      bad++; $display("[TB] FAIL ones_idle_after: got %h expected 0", {m_busy, m_done, m_ld, m_iaddr, m_waddr});
    end
    total++;
    if (m_addr !== 12'(NPIX - 1)) begin bad++; $display("[TB] FAIL ones_addr_hold: got %0d expected %0d", m_addr, NPIX - 1); end
    total++;
    if (m_data !== 8'd9) begin bad++; $display("[TB] FAIL ones_data_hold: got %0d expected 9", m_data); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'sh7F; w_mem[i] = 8'sh7F; end
    applyStimulus(0, 10'd0, 0, 0);
    total++;
    if (wr_addr_q.size() != NPIX) begin bad++; $display("[TB] FAIL sat_writes: got %0d expected %0d", wr_addr_q.size(), NPIX); end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      total++;
      if (wr_data_q[i] !== 8'h7F) begin bad++; $display("[TB] FAIL sat_data[%0d]: got %h expected 7f", i, wr_data_q[i]); end
    end
  endtask

  task automatic test_negative_shift();
    logic [7:0] exp_v;
`ifdef CONV_RELU_EN
    exp_v = 8'h00;
`else
    exp_v = 8'h80;
`endif
    for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'sh7F; w_mem[i] = -8'sd128; end
    applyStimulus(1, 10'd0, 0, 0);
    total++;
    if (wr_addr_q.size() != NPIX) begin bad++; $display("[TB] FAIL neg_writes: got %0d expected %0d", wr_addr_q.size(), NPIX); end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      total++;
      if (wr_data_q[i] !== exp_v) begin bad++; $display("[TB] FAIL neg_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_v); end
    end
  endtask

  task automatic test_centre_tap();
    int e;
    for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'(i % 128); w_mem[i] = 8'sd0; end
    w_mem[4] = 8'sd1;
    applyStimulus(0, 10'd0, 0, 0);
    total++;
    if (wr_addr_q.size() != NPIX) begin bad++; $display("[TB] FAIL centre_writes: got %0d expected %0d", wr_addr_q.size(), NPIX); end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      e = (((i / OUT_W) + 1) * IMG_W + (i % OUT_W) + 1) % 128;
      total++;
      if (wr_data_q[i] !== 8'(e)) begin bad++; $display("[TB] FAIL centre_data[%0d]: got %0d expected %0d", i, wr_data_q[i], e); end
    end
  endtask

  task automatic test_wrap_base();
    int e;
    for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'($urandom); w_mem[i] = 8'($urandom); end
    applyStimulus(1, 10'h3FE, 5, 0);
    total++;
    if (wa_q.size() != NPIX * KS * KS) begin bad++; $display("[TB] FAIL wrap_mac_cycles: got %0d expected %0d", wa_q.size(), NPIX * KS * KS); end
    for (int i = 0; i < wa_q.size(); i++) begin
      e = (10'h3FE + (i % (KS * KS))) % 1024;
      total++;
      if (wa_q[i] !== 10'(e)) begin bad++; $display("[TB] FAIL wrap_w_addr[%0d]: got %h expected %h", i, wa_q[i], e); end
    end
    total++;
    if (wr_addr_q.size() != NPIX) begin bad++; $display("[TB] FAIL wrap_writes: got %0d expected %0d", wr_addr_q.size(), NPIX); end
    total++;
    if (done_cnt != 1) begin bad++; $display("[TB] FAIL wrap_done_pulses: got %0d expected 1", done_cnt); end
    total++;
    if (busy_cnt != PASS_CYC) begin bad++; $display("[TB] FAIL wrap_busy_cycles: got %0d expected %0d", busy_cnt, PASS_CYC); end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      e = model_pixel(i / OUT_W, i % OUT_W, 10'h3FE, 7);
      total++;
      if (wr_addr_q[i] !== 12'(i)) begin bad++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], i); end
      total++;
      if (wr_data_q[i] !== 8'(e)) begin bad++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, wr_data_q[i], 8'(e)); end
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [9:0] base;
    int         e;
    int         stray;
    for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'($urandom); w_mem[i] = 8'($urandom); end
    base = 10'($urandom);
    applyStimulus(0, base, 0, 500);
    total++;
    if (m_busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy_before: got %0d expected 1", m_busy); end
    reset = 1'b1;
    #1;
    total++;
    if ({m_busy, m_ld, m_done} !== 3'b000) begin bad++; $display("[TB] FAIL abort_same_cycle: got %b expected 000", {m_busy, m_ld, m_done}); end
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (m_busy || m_ld || m_done) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("[TB] FAIL abort_no_activity: got %0d expected 0", stray); end
    base = 10'($urandom);
    applyStimulus(0, base, 0, 0);
    total++;
    if (wr_addr_q.size() != NPIX) begin bad++; $display("[TB] FAIL restart_writes: got %0d expected %0d", wr_addr_q.size(), NPIX); end
    total++;
    if (done_at - busy_rise != PASS_CYC) begin bad++; $display("[TB] FAIL restart_latency: got %0d expected %0d", done_at - busy_rise, PASS_CYC); end
    for (int i = 0; i < wr_data_q.size(); i++) begin
      e = model_pixel(i / OUT_W, i % OUT_W, int'(base), 0);
      total++;
      if (wr_addr_q[i] !== 12'(i)) begin bad++; $display("[TB] FAIL restart_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], i); end
      total++;
      if (wr_data_q[i] !== 8'(e)) begin bad++; $display("[TB] FAIL restart_data[%0d]: got %h expected %h", i, wr_data_q[i], 8'(e)); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_saturate();
    test_negative_shift();
    test_centre_tap();
    test_wrap_base();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
